run_ctrl: RTL and testbench

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/run_ctrl_pkg.sv | 28 ++
 rtl/run_ctrl_cnt.sv | 32 +++
 rtl/run_ctrl.sv | 172 +++++++++++++++++
 tb/tb_run_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types for the run controller: FSM state and run verdict encodings,
// plus the sizing helper for the shared phase counter.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RESET = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        STAT_NONE    = 2'd0,
        STAT_PASS    = 2'd1,
        STAT_FAIL    = 2'd2,
        STAT_TIMEOUT = 2'd3
    } status_e;

    // Width needed to hold the larger of the two phase lengths (never below 1).
    function automatic int unsigned phase_cnt_w(input int unsigned rst_cycles,
                                                input int unsigned drain_cycles);
        int unsigned m;
        m = (rst_cycles > drain_cycles) ? rst_cycles : drain_cycles;
        return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/run_ctrl_cnt.sv
// Loadable down-counter with zero and last-cycle flags; sequences the
// fixed-length RESET and DRAIN phases of the run controller.
module run_ctrl_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         ck,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero,
    output logic         o_last
);

    logic [W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);
    assign o_last = (r_count == W'(1));

endmodule

// File: rtl/run_ctrl.sv
// Test-run sequencer: holds the DUT in reset, runs it until done/abort/timeout,
// drains, then reports a latched verdict with a one-cycle finished pulse.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 10000,
    parameter int unsigned DRAIN_CYCLES   = 4,
    parameter int unsigned CYC_W          = 32
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             dut_done,
    input  logic             dut_pass,
    output logic             dut_rst,
    output logic             running,
    output logic             finished,
    output logic [1:0]       status,
    output logic [CYC_W-1:0] cycle_count
);

    localparam int unsigned      CNT_W        = phase_cnt_w(RST_CYCLES, DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] RST_LOAD     = CNT_W'(RST_CYCLES);
    localparam logic [CNT_W-1:0] DRAIN_LOAD   = CNT_W'(DRAIN_CYCLES);
    localparam logic [CYC_W-1:0] TIMEOUT_LAST = (TIMEOUT_CYCLES == 0) ? '0
                                                : CYC_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       r_rst_sync;
    logic             w_rst_n_int;

    state_e           r_state;
    state_e           w_state_next;
    status_e          r_status;
    status_e          w_status_next;
    logic [CYC_W-1:0] r_cycle_count;
    logic [CYC_W-1:0] w_count_next;
    logic [CYC_W-1:0] w_count_inc;
    logic             r_dut_rst;
    logic             r_running;
    logic             r_finished;

    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_load_val;
    logic             w_cnt_dec;
    logic             w_cnt_zero;
    logic             w_cnt_last;
    logic             w_phase_end;
    logic             w_timeout;
    logic             w_run_exit;

    // NOTE: reset asserts asynchronously but releases only after two ck edges,
    // so no flop sees rst_n deassert close to a clock edge.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n_int = r_rst_sync[1];

    run_ctrl_cnt #(
        .W (CNT_W)
    ) u_phase_cnt (
        .ck         (ck),
        .rst_n      (w_rst_n_int),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero),
        .o_last     (w_cnt_last)
    );

    // A zero count also ends a phase, so a mis-sized load can never stall the FSM.
    assign w_phase_end = w_cnt_last | w_cnt_zero;
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_cycle_count == TIMEOUT_LAST);
    assign w_count_inc = (r_cycle_count == '1) ? r_cycle_count
                                               : r_cycle_count + CYC_W'(1);

    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        w_state_next   = r_state;
        w_status_next  = r_status;
        w_count_next   = r_cycle_count;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = '0;
        w_cnt_dec      = 1'b0;
        w_run_exit     = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next   = S_RESET;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = RST_LOAD;
                    w_status_next  = STAT_NONE;
                    w_count_next   = '0;
                end
            end
            S_RESET: begin
                w_cnt_dec    = 1'b1;
                w_count_next = '0;
                if (w_phase_end) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_count_next = w_count_inc;
                if (abort) begin
                    w_status_next = STAT_FAIL;
                    w_run_exit    = 1'b1;
                end else if (dut_done) begin
                    w_status_next = dut_pass ? STAT_PASS : STAT_FAIL;
                    w_run_exit    = 1'b1;
                end else if (w_timeout) begin
                    w_status_next = STAT_TIMEOUT;
                    w_run_exit    = 1'b1;
                end
                if (w_run_exit) begin
                    if (DRAIN_CYCLES != 0) begin
                        w_state_next   = S_DRAIN;
                        w_cnt_load     = 1'b1;
                        w_cnt_load_val = DRAIN_LOAD;
                    end else begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_DRAIN: begin
                w_cnt_dec = 1'b1;
                if (w_phase_end) begin
                    w_state_next = S_DONE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge
    // as the state itself.
    always_ff @(posedge ck or negedge w_rst_n_int) begin
        if (!w_rst_n_int) begin
            r_state       <= S_IDLE;
            r_status      <= STAT_NONE;
            r_cycle_count <= '0;
            r_dut_rst     <= 1'b1;
            r_running     <= 1'b0;
            r_finished    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_status      <= w_status_next;
            r_cycle_count <= w_count_next;
            r_dut_rst     <= (w_state_next == S_IDLE) || (w_state_next == S_RESET) ||
                             (w_state_next == S_DONE);
            r_running     <= (w_state_next == S_RUN);
            r_finished    <= (w_state_next == S_DONE) && (r_state != S_DONE);
        end
    end

    assign dut_rst     = r_dut_rst;
    assign running     = r_running;
    assign finished    = r_finished;
    assign status      = r_status;
    assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: three instances cover default timing, a short
// timeout, and zero-drain with a narrow saturating cycle counter.
module tb_run_ctrl;

    localparam logic [1:0] NONE    = 2'd0;
    localparam logic [1:0] PASS    = 2'd1;
    localparam logic [1:0] FAIL_ST = 2'd2;
    localparam logic [1:0] TMO     = 2'd3;

    logic ck = 1'b0;
    always #5 ck = ~ck;

    logic        rst_n      [3];
    logic        start      [3];
    logic        abort      [3];
    logic        dut_done   [3];
    logic        dut_pass   [3];
    logic        dut_rst_o  [3];
    logic        running_o  [3];
    logic        finished_o [3];
    logic [1:0]  status_o   [3];
    logic [31:0] cc_a;
    logic [31:0] cc_b;
    logic [3:0]  cc_c;

    int n_tests = 0;
    int n_fail  = 0;
    int fin_cnt [3];

    run_ctrl u_dut_a (
        .ck(ck), .rst_n(rst_n[0]), .start(start[0]), .abort(abort[0]),
        .dut_done(dut_done[0]), .dut_pass(dut_pass[0]), .dut_rst(dut_rst_o[0]),
        .running(running_o[0]), .finished(finished_o[0]), .status(status_o[0]),
        .cycle_count(cc_a)
    );

    run_ctrl #(.TIMEOUT_CYCLES(50)) u_dut_b (
        .ck(ck), .rst_n(rst_n[1]), .start(start[1]), .abort(abort[1]),
        .dut_done(dut_done[1]), .dut_pass(dut_pass[1]), .dut_rst(dut_rst_o[1]),
        .running(running_o[1]), .finished(finished_o[1]), .status(status_o[1]),
        .cycle_count(cc_b)
    );

    run_ctrl #(.RST_CYCLES(2), .TIMEOUT_CYCLES(0), .DRAIN_CYCLES(0), .CYC_W(4)) u_dut_c (
        .ck(ck), .rst_n(rst_n[2]), .start(start[2]), .abort(abort[2]),
        .dut_done(dut_done[2]), .dut_pass(dut_pass[2]), .dut_rst(dut_rst_o[2]),
        .running(running_o[2]), .finished(finished_o[2]), .status(status_o[2]),
        .cycle_count(cc_c)
    );

    always @(negedge ck) begin
        for (int i = 0; i < 3; i++) begin
            if (finished_o[i] === 1'b1) fin_cnt[i]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] get_cc(input int i);
        case (i)
            0:       return cc_a;
            1:       return cc_b;
            default: return {28'd0, cc_c};
        endcase
    endfunction

    task automatic check_outs(input string tag, input int i, input logic e_rst,
                              input logic e_run, input logic e_fin,
                              input logic [1:0] e_st, input logic [31:0] e_cc);
        check($sformatf("%s.dut_rst", tag),  {31'd0, dut_rst_o[i]},  {31'd0, e_rst});
        check($sformatf("%s.running", tag),  {31'd0, running_o[i]},  {31'd0, e_run});
        check($sformatf("%s.finished", tag), {31'd0, finished_o[i]}, {31'd0, e_fin});
        check($sformatf("%s.status", tag),   {30'd0, status_o[i]},   {30'd0, e_st});
        check($sformatf("%s.cc", tag),       get_cc(i),              e_cc);
    endtask

    // Called at a negedge; returns at the negedge of the first RUN cycle with
    // the number of cycles dut_rst stayed high after start was accepted.
    task automatic start_run(input int i, input bit hold, output int rst_len);
        start[i] = 1'b1;
        @(negedge ck);
        if (!hold) start[i] = 1'b0;
        rst_len = 0;
        while (dut_rst_o[i] === 1'b1 && rst_len < 100) begin
            rst_len++;
            @(negedge ck);
        end
    endtask

    task automatic wait_finished(input int i, output int n);
        n = 0;
        while (finished_o[i] !== 1'b1 && n < 200) begin
            @(negedge ck);
            n++;
        end
    endtask

    initial begin
        int len;
        int n;
        int f0;

        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; start[i] = 1'b0; abort[i] = 1'b0;
            dut_done[i] = 1'b0; dut_pass[i] = 1'b0; fin_cnt[i] = 0;
        end
        repeat (3) @(negedge ck);
        for (int i = 0; i < 3; i++) check_outs($sformatf("reset%0d", i), i, 1, 0, 0, NONE, 0);
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        repeat (5) @(negedge ck);
        check_outs("idle_a", 0, 1, 0, 0, NONE, 0);

        // A1: 20-cycle passing run, inputs ignored during DRAIN and DONE
        start_run(0, 0, len);
        check("a1.rst_len", len, 8);
        check_outs("a1.run1", 0, 0, 1, 0, NONE, 0);
        repeat (19) @(negedge ck);
        check("a1.cc19", get_cc(0), 19);
        dut_done[0] = 1'b1; dut_pass[0] = 1'b1;
        @(negedge ck);
        check_outs("a1.exit", 0, 0, 0, 0, PASS, 20);
        abort[0] = 1'b1; dut_done[0] = 1'b1; dut_pass[0] = 1'b0;
        wait_finished(0, n);
        check("a1.drain_len", n, 4);
        check_outs("a1.done", 0, 1, 0, 1, PASS, 20);
        repeat (3) @(negedge ck);
        check_outs("a1.hold", 0, 1, 0, 0, PASS, 20);
        abort[0] = 1'b0; dut_done[0] = 1'b0;

        // A2: start held high through RESET/RUN, fail verdict in first RUN cycle
        start_run(0, 1, len);
        check("a2.rst_len", len, 8);
        check_outs("a2.run1", 0, 0, 1, 0, NONE, 0);
        dut_done[0] = 1'b1; dut_pass[0] = 1'b0;
        @(negedge ck);
        dut_done[0] = 1'b0; start[0] = 1'b0;
        check_outs("a2.exit", 0, 0, 0, 0, FAIL_ST, 1);
        wait_finished(0, n);
        check("a2.drain_len", n, 4);
        @(negedge ck);

        // A3: asynchronous reset in RUN cycle 10 abandons the run
        start_run(0, 0, len);
        check("a3.rst_len", len, 8);
        check("a3.status_cleared", {30'd0, status_o[0]}, {30'd0, NONE});
        repeat (9) @(negedge ck);
        check("a3.cc9", get_cc(0), 9);
        f0 = fin_cnt[0];
        rst_n[0] = 1'b0;
        #1;
        check_outs("a3.rst", 0, 1, 0, 0, NONE, 0);
        repeat (2) @(negedge ck);
        rst_n[0] = 1'b1;
        repeat (10) @(negedge ck);
        check_outs("a3.idle", 0, 1, 0, 0, NONE, 0);
        check("a3.no_fin", fin_cnt[0] - f0, 0);

        // B1: timeout after 50 RUN cycles
        f0 = fin_cnt[1];
        start_run(1, 0, len);
        check("b1.rst_len", len, 8);
        repeat (49) @(negedge ck);
        check_outs("b1.cyc50", 1, 0, 1, 0, NONE, 49);
        @(negedge ck);
        check_outs("b1.exit", 1, 0, 0, 0, TMO, 50);
        wait_finished(1, n);
        check("b1.drain_len", n, 4);
        repeat (5) @(negedge ck);
        check("b1.one_fin", fin_cnt[1] - f0, 1);

        // B2: abort beats a passing done coincident with timeout
        start_run(1, 0, len);
        repeat (49) @(negedge ck);
        abort[1] = 1'b1; dut_done[1] = 1'b1; dut_pass[1] = 1'b1;
        @(negedge ck);
        abort[1] = 1'b0; dut_done[1] = 1'b0;
        check_outs("b2.exit", 1, 0, 0, 0, FAIL_ST, 50);
        wait_finished(1, n);
        @(negedge ck);

        // B3: failing done beats coincident timeout
        start_run(1, 0, len);
        repeat (49) @(negedge ck);
        dut_done[1] = 1'b1; dut_pass[1] = 1'b0;
        @(negedge ck);
        dut_done[1] = 1'b0;
        check_outs("b3.exit", 1, 0, 0, 0, FAIL_ST, 50);
        wait_finished(1, n);
        @(negedge ck);

        // B4: passing done one cycle before the timeout cycle
        start_run(1, 0, len);
        repeat (48) @(negedge ck);
        dut_done[1] = 1'b1; dut_pass[1] = 1'b1;
        @(negedge ck);
        dut_done[1] = 1'b0;
        check_outs("b4.exit", 1, 0, 0, 0, PASS, 49);

        // C1: no drain, no timeout, 4-bit count saturates at 15
        start_run(2, 0, len);
        check("c1.rst_len", len, 2);
        repeat (19) @(negedge ck);
        check("c1.cc_sat", get_cc(2), 15);
        dut_done[2] = 1'b1; dut_pass[2] = 1'b1;
        @(negedge ck);
        dut_done[2] = 1'b0;
        check_outs("c1.done", 2, 1, 0, 1, PASS, 15);

        // C2: back-to-back start in the first DONE cycle
        start_run(2, 0, len);
        check("c2.rst_len", len, 2);
        check_outs("c2.run1", 2, 0, 1, 0, NONE, 0);
        repeat (3) @(negedge ck);
        check_outs("c2.run4", 2, 0, 1, 0, NONE, 3);
        dut_done[2] = 1'b1; dut_pass[2] = 1'b0;
        @(negedge ck);
        dut_done[2] = 1'b0;
        check_outs("c2.done", 2, 1, 0, 1, FAIL_ST, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
